chess_time_keeper: RTL

- Consumer end of the game-state FSM's one-hot outputs (p1, p2, Load, ff).
- Holds one countdown clock per player as minutes:seconds, decrements the active player's clock once per second, and applies a per-move increment on each hand-over.
- Flags a timeout and raises game_over.
- Feeds the display/readout logic; does not drive the FSM.

---
 rtl/chess_time_keeper.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/chess_time_keeper.sv
// Two-player chess clock: per-player minutes:seconds countdown, one-second
// prescaler, per-move increment on hand-over, sticky timeout flags.
module chess_time_keeper #(
  parameter int TICK_DIV = 50000000,
  parameter int INIT_MIN = 5,
  parameter int INIT_SEC = 0,
  parameter int INC_SEC  = 0,
  parameter int LOW_SEC  = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ff,
  input  logic       Load,
  input  logic       p1,
  input  logic       p2,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  output logic [6:0] p1_min,
  output logic [5:0] p1_sec,
  output logic [6:0] p2_min,
  output logic [5:0] p2_sec,
  output logic       p1_flag,
  output logic       p2_flag,
  output logic       p1_low,
  output logic       p2_low,
  output logic       game_over
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [12:0]   INIT_CLK   = {7'(INIT_MIN), 6'(INIT_SEC)};

  typedef enum logic [1:0] {SEL_NONE, SEL_P1, SEL_P2} sel_t;
  typedef enum logic [2:0] {IDLE, RUN1, RUN2, PAUSED, OVER} state_t;

  // Clocks are packed as {minutes[6:0], seconds[5:0]}.
  logic [12:0]   clk1, clk2;
  logic [PW-1:0] presc;
  logic          flag1, flag2;
  sel_t          sel, prev_sel, last_sel;
  state_t        state, state_next;

  logic live, changed, count_en, tick, tick1, tick2, inc1, inc2, expire1, expire2;
  logic clear_all;
  logic [12:0] load_clk;

  // One-second decrement; 0:00 is a fixed point.
  function automatic logic [12:0] dec_clk(input logic [12:0] c);
    logic [6:0] m;
    logic [5:0] s;
    m = c[12:6];
    s = c[5:0];
    if (s != 6'd0)      dec_clk = {m, s - 6'd1};
    else if (m != 7'd0) dec_clk = {m - 7'd1, 6'd59};
    else                dec_clk = c;
  endfunction

  // Add the per-move increment with seconds carry, saturating at 99:59.
  function automatic logic [12:0] add_inc(input logic [12:0] c);
    logic [7:0] m;
    logic [6:0] s;
    s = {1'b0, c[5:0]} + 7'(INC_SEC);
    m = {1'b0, c[12:6]};
    if (s >= 7'd60) begin
      s = s - 7'd60;
      m = m + 8'd1;
    end
    if (m > 8'd99) add_inc = {7'd99, 6'd59};
    else           add_inc = {m[6:0], s[5:0]};
  endfunction

  assign sel       = (p1 && !p2) ? SEL_P1 : ((p2 && !p1) ? SEL_P2 : SEL_NONE);
  assign clear_all = !Reset || ff;
  assign load_clk  = {(load_min > 7'd99) ? 7'd99 : load_min,
                      (load_sec > 6'd59) ? 6'd59 : load_sec};

  // State register: any clear/preset returns to IDLE.
  always_ff @(posedge Clock) begin
    if (clear_all || Load) state <= IDLE;
    else                   state <= state_next;
  end

  // Next state: OVER is absorbing; otherwise follow the player decode.
  always_comb begin
    state_next = state;
    if (state != OVER) begin
      if (expire1 || expire2) state_next = OVER;
      else begin
        case (sel)
          SEL_P1:  state_next = RUN1;
          SEL_P2:  state_next = RUN2;
          default: state_next = (state == IDLE) ? IDLE : PAUSED;
        endcase
      end
    end
  end

  // Control outputs: prescaler clear/count, tick, increment and expiry strobes.
  always_comb begin
    live     = (state != OVER);
    changed  = live && (sel != prev_sel);
    count_en = live && !changed && (sel != SEL_NONE);
    tick     = count_en && (presc == PRESC_LAST);
    tick1    = tick && (sel == SEL_P1);
    tick2    = tick && (sel == SEL_P2);
    inc1     = changed && (sel == SEL_P2) && (last_sel == SEL_P1);
    inc2     = changed && (sel == SEL_P1) && (last_sel == SEL_P2);
    expire1  = tick1 && (clk1 == {7'd0, 6'd1});
    expire2  = tick2 && (clk2 == {7'd0, 6'd1});
  end

  // Datapath: clocks, prescaler, flags and player history.
  always_ff @(posedge Clock) begin
    if (clear_all || Load) begin
      clk1     <= clear_all ? INIT_CLK : load_clk;
      clk2     <= clear_all ? INIT_CLK : load_clk;
      presc    <= '0;
      flag1    <= 1'b0;
      flag2    <= 1'b0;
      prev_sel <= SEL_NONE;
      last_sel <= SEL_NONE;
    end else if (live) begin
      prev_sel <= sel;
      if (sel != SEL_NONE) last_sel <= sel;
      if (changed)       presc <= '0;
      else if (count_en) presc <= tick ? '0 : presc + PW'(1);
      if (tick1)     clk1 <= dec_clk(clk1);
      else if (inc1) clk1 <= add_inc(clk1);
      if (tick2)     clk2 <= dec_clk(clk2);
      else if (inc2) clk2 <= add_inc(clk2);
      if (expire1) flag1 <= 1'b1;
      if (expire2) flag2 <= 1'b1;
    end
  end

  assign p1_min    = clk1[12:6];
  assign p1_sec    = clk1[5:0];
  assign p2_min    = clk2[12:6];
  assign p2_sec    = clk2[5:0];
  assign p1_flag   = flag1;
  assign p2_flag   = flag2;
  assign game_over = flag1 | flag2;
  assign p1_low    = (p1_min == 7'd0) && (p1_sec < 6'(LOW_SEC)) && !flag1;
  assign p2_low    = (p2_min == 7'd0) && (p2_sec < 6'(LOW_SEC)) && !flag2;

endmodule
